commit: RTL and testbench
=========================

COMMIT -- requirements
Module: commit

Interface
REQ-001 SHALL declare parameters: BUF_SIZE, default from shared package, number of buffer entries.
REQ-002 SHALL declare parameters: BUF_SIZE_LOG, default from shared package, entry-index width.
REQ-003 SHALL have ports: clk  in  1  single clock, all state rising-edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: entries_all  in  entry[BUF_SIZE]  instruction buffer contents.
REQ-006 SHALL have ports: release_valid  out  1[2]  slot frees a buffer entry this cycle.
REQ-007 SHALL have ports: release_index  out  BUF_SIZE_LOG[2]  entry to set to S_NOT_USED.
REQ-008 SHALL have ports: reg_we  out  1[2]  register-file write enables.
REQ-009 SHALL have ports: reg_waddr  out  5[2]  write addresses.
REQ-010 SHALL have ports: reg_wdata  out  32[2]  write data.
REQ-011 SHALL have ports: mem_req  out  1  store write request.
REQ-012 SHALL have ports: mem_addr  out  32  store address.
REQ-013 SHALL have ports: mem_wdata  out  32  store data.
REQ-014 SHALL have ports: mem_ack  in  1  store accepted by memory.
REQ-015 SHALL have ports: retired_count  out  32  retired-instruction counter (only with macro).

Function
REQ-016 Oldest candidate SHALL be the used entry (e_state != S_NOT_USED) with the largest tag; second candidate SHALL be the entry with tag == oldest tag - 1.
REQ-017 Candidate SHALL be retirable when e_state == S_EXECUTED and speculative_tag == 0.
REQ-018 Retirement SHALL be strictly in order: slot 1 retires only if slot 0 retires in the same cycle.
REQ-019 Non-store retire SHALL assert reg_we with reg_waddr = Dest and reg_wdata = result; Dest == 0 SHALL give reg_we = 0 while the entry is still released.
REQ-020 Outputs SHALL be registered: release and register-write outputs are valid in the cycle after candidate selection (latency 1), with each pulse lasting exactly one cycle.
REQ-021 Store FSM states SHALL be IDLE and WAIT_ACK.
REQ-022 In IDLE, a retirable STORE in slot 0 SHALL cause a transition to WAIT_ACK, with mem_req = 1, mem_addr = result, and mem_wdata = Vk latched.
REQ-023 In WAIT_ACK, mem_req, mem_addr and mem_wdata SHALL be held stable.
REQ-024 On mem_ack in WAIT_ACK, the FSM SHALL go to IDLE and assert release for that store next cycle.
REQ-025 While in WAIT_ACK, no other entry SHALL retire.
REQ-026 A STORE in slot 1 SHALL never retire; slot 1 retires nothing that cycle.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 The same entry SHALL never be released twice: an entry whose release pulse is pending is excluded from selection.
REQ-029 An empty buffer or a non-retirable oldest entry SHALL produce all-zero outputs.
REQ-030 Tag wrap SHALL follow tag arithmetic modulo 2^(BUF_SIZE_LOG+1); oldest - 1 wraps from 0 to all-ones.

Reset
REQ-031 rst_n low SHALL immediately clear all outputs to 0 and force FSM = IDLE.
REQ-032 Reset mid-WAIT_ACK SHALL drop mem_req without releasing the store.

Configuration
REQ-033 With COMMIT_PERF_CNT_EN defined, retired_count SHALL add the number of entries released each cycle (0–2), wrapping at 2^32.
REQ-034 With COMMIT_PERF_CNT_EN defined, retired_count SHALL reset to 0.
REQ-035 Without COMMIT_PERF_CNT_EN, the retired_count port and its counter SHALL be absent.

Structure
REQ-036 entry, e_state values (S_NOT_USED, S_NOT_EXECUTED, S_EXECUTED), Unit values (STORE, BRANCH, ...), BUF_SIZE and BUF_SIZE_LOG SHALL live in the shared package.
REQ-037 The commit FSM state enum SHALL be local to the module.
REQ-038 One sub-module, oldest_finder, SHALL return valid/index/tag for the max-tag entry and for the oldest-1 entry.

Verification
REQ-039 Scenario: two executed non-speculative ALU entries, tags 15/14, Dest 3/4, results 0xA/0xB -> next cycle reg_we = {1,1}, addrs {3,4}, data {0xA,0xB}, both released.
REQ-040 Scenario: oldest entry tag 15 is S_NOT_EXECUTED, tag 14 is executed -> no outputs for any cycle until tag 15 executes.
REQ-041 Scenario: executed STORE, result 0x100, Vk 0x55, mem_ack after 3 cycles -> mem_req held for 3 cycles with addr 0x100 and data 0x55, release 1 cycle after ack, no other retire meanwhile.
REQ-042 Scenario: oldest entry has speculative_tag 6'b000001 -> not retired; clearing the tag -> retired next cycle.
REQ-043 Scenario: tags 0 and 31 (wrap) with tag 0 oldest and both executed -> both retire in one cycle.
REQ-044 Scenario: rst_n low during WAIT_ACK -> mem_req = 0 immediately; retired_count = 0 when COMMIT_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared definitions for the commit stage: instruction-buffer entry layout,
// buffer sizing, entry-state and functional-unit encodings, tag helpers.
package commit_pkg;

    localparam int BUF_SIZE     = 16;
    localparam int BUF_SIZE_LOG = 4;
    // Tags carry one extra bit so age order survives wrap-around.
    localparam int TAG_W        = BUF_SIZE_LOG + 1;

    typedef enum logic [1:0] {
        S_NOT_USED     = 2'd0,
        S_NOT_EXECUTED = 2'd1,
        S_EXECUTED     = 2'd2
    } e_state_t;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        MUL    = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4
    } unit_t;

    typedef struct packed {
        e_state_t          e_state;
        unit_t             unit;
        logic [TAG_W-1:0]  tag;
        logic [5:0]        speculative_tag;
        logic [4:0]        dest;
        logic [31:0]       result;
        logic [31:0]       vk;
    } entry;

    // a is older (larger in wrap-aware tag order) than b. Live tags always span
    // less than half of the tag space, so the sign of (a - b) decides.
    function automatic logic tag_older(input logic [TAG_W-1:0] a,
                                       input logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] diff;
        diff = a - b;
        return (diff != '0) && !diff[TAG_W-1];
    endfunction

    // Entry has finished execution and no longer depends on a branch.
    function automatic logic is_retirable(input entry e);
        return (e.e_state == S_EXECUTED) && (e.speculative_tag == 6'd0);
    endfunction

endpackage

// File: rtl/commit_oldest_finder.sv
// Locates the oldest live buffer entry (largest wrap-aware tag) and the entry
// directly behind it (tag == oldest - 1). Entries flagged in exclude are
// treated as already gone.
module oldest_finder
    import commit_pkg::*;
#(
    parameter int BUF_SIZE     = commit_pkg::BUF_SIZE,
    parameter int BUF_SIZE_LOG = commit_pkg::BUF_SIZE_LOG
) (
    input  entry [BUF_SIZE-1:0]     entries,
    input  logic [BUF_SIZE-1:0]     exclude,
    output logic                    old_valid,
    output logic [BUF_SIZE_LOG-1:0] old_index,
    output logic [TAG_W-1:0]        old_tag,
    output logic                    sec_valid,
    output logic [BUF_SIZE_LOG-1:0] sec_index,
    output logic [TAG_W-1:0]        sec_tag
);

    // Linear max-scan over live entries for the oldest tag.
    always_comb begin
        old_valid = 1'b0;
        old_index = '0;
        old_tag   = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (entries[i].e_state != S_NOT_USED && !exclude[i] &&
                (!old_valid || tag_older(entries[i].tag, old_tag))) begin
                old_valid = 1'b1;
                old_index = BUF_SIZE_LOG'(i);
                old_tag   = entries[i].tag;
            end
        end
    end

    // Exact-match search for the next-oldest tag, wrapping 0 -> all-ones.
    always_comb begin
        sec_valid = 1'b0;
        sec_index = '0;
        sec_tag   = old_tag - TAG_W'(1);
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (old_valid && !sec_valid && entries[i].e_state != S_NOT_USED &&
                !exclude[i] && entries[i].tag == sec_tag) begin
                sec_valid = 1'b1;
                sec_index = BUF_SIZE_LOG'(i);
            end
        end
    end

endmodule

// File: rtl/commit.sv
// In-order commit stage: retires up to two executed, non-speculative entries
// per cycle into the register file and performs stores one at a time through
// a request/ack memory port. All outputs are registered (one cycle latency).
// mem_req/mem_ack: mem_req is held with stable addr/data until mem_ack is
// seen high on a rising edge; mem_ack outside an outstanding request is ignored.
// Optional feature: define COMMIT_PERF_CNT_EN to add the retired_count port.
module commit
    import commit_pkg::*;
#(
    parameter int BUF_SIZE     = commit_pkg::BUF_SIZE,
    parameter int BUF_SIZE_LOG = commit_pkg::BUF_SIZE_LOG
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  entry [BUF_SIZE-1:0]           entries_all,
    output logic [1:0]                    release_valid,
    output logic [1:0][BUF_SIZE_LOG-1:0]  release_index,
    output logic [1:0]                    reg_we,
    output logic [1:0][4:0]               reg_waddr,
    output logic [1:0][31:0]              reg_wdata,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    output logic                          dbg_state
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]                   retired_count
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_ACK = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [BUF_SIZE_LOG-1:0]        store_idx_q, store_idx_d;
    logic [1:0]                     release_valid_q, release_valid_d;
    logic [1:0][BUF_SIZE_LOG-1:0]   release_index_q, release_index_d;
    logic [1:0]                     reg_we_q, reg_we_d;
    logic [1:0][4:0]                reg_waddr_q, reg_waddr_d;
    logic [1:0][31:0]               reg_wdata_q, reg_wdata_d;
    logic                           mem_req_q, mem_req_d;
    logic [31:0]                    mem_addr_q, mem_addr_d;
    logic [31:0]                    mem_wdata_q, mem_wdata_d;

    logic [BUF_SIZE-1:0]            pending;
    logic                           old_valid, sec_valid;
    logic [BUF_SIZE_LOG-1:0]        old_index, sec_index;
    logic [TAG_W-1:0]               old_tag, sec_tag;
    entry                           e0, e1;
    logic                           slot0_ok, slot1_ok, start_store;

    // Entries released last cycle are still marked used in the buffer this cycle.
    always_comb begin
        pending = '0;
        for (int k = 0; k < 2; k++) begin
            if (release_valid_q[k]) pending[release_index_q[k]] = 1'b1;
        end
    end

    oldest_finder #(
        .BUF_SIZE     (BUF_SIZE),
        .BUF_SIZE_LOG (BUF_SIZE_LOG)
    ) u_finder (
        .entries   (entries_all),
        .exclude   (pending),
        .old_valid (old_valid),
        .old_index (old_index),
        .old_tag   (old_tag),
        .sec_valid (sec_valid),
        .sec_index (sec_index),
        .sec_tag   (sec_tag)
    );

    assign e0 = entries_all[old_index];
    assign e1 = entries_all[sec_index];

    // Candidate qualification; the tag compare ties each index to its match.
    assign slot0_ok    = old_valid && (e0.tag == old_tag) && is_retirable(e0);
    assign slot1_ok    = slot0_ok && (e0.unit != STORE) && sec_valid &&
                         (e1.tag == sec_tag) && is_retirable(e1) && (e1.unit != STORE);
    assign start_store = slot0_ok && (e0.unit == STORE);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            store_idx_q     <= '0;
            release_valid_q <= '0;
            release_index_q <= '0;
            reg_we_q        <= '0;
            reg_waddr_q     <= '0;
            reg_wdata_q     <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            store_idx_q     <= store_idx_d;
            release_valid_q <= release_valid_d;
            release_index_q <= release_index_d;
            reg_we_q        <= reg_we_d;
            reg_waddr_q     <= reg_waddr_d;
            reg_wdata_q     <= reg_wdata_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    // Next state: a retirable store in slot 0 opens a memory transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_store) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (mem_ack)     state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Output decode for the next cycle's registered outputs.
    always_comb begin
        store_idx_d     = store_idx_q;
        release_valid_d = '0;
        release_index_d = '0;
        reg_we_d        = '0;
        reg_waddr_d     = '0;
        reg_wdata_d     = '0;
        mem_req_d       = 1'b0;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_store) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = e0.result;
                    mem_wdata_d = e0.vk;
                    store_idx_d = old_index;
                end else if (slot0_ok) begin
                    release_valid_d[0] = 1'b1;
                    release_index_d[0] = old_index;
                    if (e0.dest != 5'd0) begin
                        reg_we_d[0]    = 1'b1;
                        reg_waddr_d[0] = e0.dest;
                        reg_wdata_d[0] = e0.result;
                    end
                    if (slot1_ok) begin
                        release_valid_d[1] = 1'b1;
                        release_index_d[1] = sec_index;
                        if (e1.dest != 5'd0) begin
                            reg_we_d[1]    = 1'b1;
                            reg_waddr_d[1] = e1.dest;
                            reg_wdata_d[1] = e1.result;
                        end
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (mem_ack) begin
                    release_valid_d[0] = 1'b1;
                    release_index_d[0] = store_idx_q;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            default: ;
        endcase
    end

    assign release_valid = release_valid_q;
    assign release_index = release_index_q;
    assign reg_we        = reg_we_q;
    assign reg_waddr     = reg_waddr_q;
    assign reg_wdata     = reg_wdata_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign dbg_state     = (state_q == ST_WAIT_ACK);

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] retired_count_q, retired_count_d;

    // Count entries whose release pulse is on the outputs this cycle.
    always_comb begin
        retired_count_d = retired_count_q + 32'(release_valid_q[0]) + 32'(release_valid_q[1]);
    end

    // Free-running retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_count_q <= '0;
        else        retired_count_q <= retired_count_d;
    end

    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_commit.sv
// Testbench for commit: directed buffer scenarios, a small buffer model that
// frees released entries, and a scoreboard of expected release/write records.
module tb_commit;
  import commit_pkg::*;

  localparam int W = 86;

  logic                          clk;
  logic                          rst_n;
  entry [BUF_SIZE-1:0]           ents;
  logic [1:0]                    release_valid;
  logic [1:0][BUF_SIZE_LOG-1:0]  release_index;
  logic [1:0]                    reg_we;
  logic [1:0][4:0]               reg_waddr;
  logic [1:0][31:0]              reg_wdata;
  logic                          mem_req;
  logic [31:0]                   mem_addr;
  logic [31:0]                   mem_wdata;
  logic                          mem_ack;
  logic                          dbg_state;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0]                   retired_count;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int exp_retired = 0;

  commit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entries_all   (ents),
    .release_valid (release_valid),
    .release_index (release_index),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .dbg_state     (dbg_state)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .retired_count (retired_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic entry mk_ent(input e_state_t st, input unit_t u, input logic [TAG_W-1:0] tag,
                                  input logic [5:0] spec, input logic [4:0] dest,
                                  input logic [31:0] res, input logic [31:0] vk);
    entry e;
    e.e_state = st; e.unit = u; e.tag = tag; e.speculative_tag = spec;
    e.dest = dest; e.result = res; e.vk = vk;
    return e;
  endfunction

  // layout: rv[85:84] i1[83:80] i0[79:76] we[75:74] a1[73:69] a0[68:64] d1[63:32] d0[31:0]
  task automatic push_exp(input logic [1:0] rv, input logic [3:0] i0, input logic [3:0] i1,
                          input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    exp_q.push_back({rv, i1, i0, we, a1, a0, d1, d0});
    exp_retired += int'(rv[0]) + int'(rv[1]);
  endtask

  // one cycle; the buffer frees entries whose release pulse was on the outputs
  task automatic step();
    logic [1:0] rv;
    logic [1:0][BUF_SIZE_LOG-1:0] ri;
    @(negedge clk);
    rv = release_valid;
    ri = release_index;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) if (rv[k]) ents[ri[k]].e_state = S_NOT_USED;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string name);
    tick(3);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && (release_valid != 2'b00 || reg_we != 2'b00)) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", {60'd0, release_valid, reg_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("release_valid", 64'(release_valid), 64'(e[85:84]));
        if (e[84]) check("release_index0", 64'(release_index[0]), 64'(e[79:76]));
        if (e[85]) check("release_index1", 64'(release_index[1]), 64'(e[83:80]));
        check("reg_we", 64'(reg_we), 64'(e[75:74]));
        if (e[74]) begin
          check("reg_waddr0", 64'(reg_waddr[0]), 64'(e[68:64]));
          check("reg_wdata0", 64'(reg_wdata[0]), 64'(e[31:0]));
        end
        if (e[75]) begin
          check("reg_waddr1", 64'(reg_waddr[1]), 64'(e[73:69]));
          check("reg_wdata1", 64'(reg_wdata[1]), 64'(e[63:32]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0;
    ents = '0;
    #1;
    check("reset_release_valid", 64'(release_valid), 64'd0);
    check("reset_reg_we", 64'(reg_we), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_fsm", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // two ALU entries retire together
    ents[2] = mk_ent(S_EXECUTED, ALU, 5'd15, 6'd0, 5'd3, 32'hA, 32'h0);
    ents[5] = mk_ent(S_EXECUTED, ALU, 5'd14, 6'd0, 5'd4, 32'hB, 32'h0);
    push_exp(2'b11, 4'd2, 4'd5, 2'b11, 5'd3, 5'd4, 32'hA, 32'hB);
    drain("dual_retire_drain");

    // oldest not executed blocks younger executed entry
    ents[3] = mk_ent(S_NOT_EXECUTED, ALU, 5'd15, 6'd0, 5'd1, 32'h11, 32'h0);
    ents[7] = mk_ent(S_EXECUTED, MUL, 5'd14, 6'd0, 5'd6, 32'h77, 32'h0);
    tick(4);
    check("blocked_no_output", 64'(exp_q.size()), 64'd0);
    ents[3].e_state = S_EXECUTED;
    push_exp(2'b11, 4'd3, 4'd7, 2'b11, 5'd1, 5'd6, 32'h11, 32'h77);
    drain("in_order_drain");

    // store in slot 0, ack on third request cycle; ALU behind it waits
    ents[4] = mk_ent(S_EXECUTED, STORE, 5'd10, 6'd0, 5'd0, 32'h100, 32'h55);
    ents[6] = mk_ent(S_EXECUTED, ALU, 5'd9, 6'd0, 5'd5, 32'h99, 32'h0);
    push_exp(2'b01, 4'd4, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    push_exp(2'b01, 4'd6, 4'd0, 2'b01, 5'd5, 5'd0, 32'h99, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("store_mem_req", 64'(mem_req), 64'd1);
      check("store_mem_addr", 64'(mem_addr), 64'h100);
      check("store_mem_wdata", 64'(mem_wdata), 64'h55);
      check("store_wait_state", 64'(dbg_state), 64'd1);
      if (c == 2) mem_ack = 1'b1;
    end
    step();
    mem_ack = 1'b0;
    check("store_req_dropped", 64'(mem_req), 64'd0);
    check("store_back_idle", 64'(dbg_state), 64'd0);
    drain("store_drain");

    // store in slot 1 does not retire alongside slot 0
    ents[0] = mk_ent(S_EXECUTED, ALU, 5'd20, 6'd0, 5'd7, 32'h70, 32'h0);
    ents[1] = mk_ent(S_EXECUTED, STORE, 5'd19, 6'd0, 5'd0, 32'h200, 32'h66);
    push_exp(2'b01, 4'd0, 4'd0, 2'b01, 5'd7, 5'd0, 32'h70, 32'h0);
    push_exp(2'b01, 4'd1, 4'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    step();
    check("slot1_store_no_req", 64'(mem_req), 64'd0);
    step();
    check("slot1_store_req", 64'(mem_req), 64'd1);
    check("slot1_store_addr", 64'(mem_addr), 64'h200);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("slot1_store_done", 64'(mem_req), 64'd0);
    drain("slot1_store_drain");

    // speculative entry held until its tag clears
    ents[8] = mk_ent(S_EXECUTED, BRANCH, 5'd3, 6'b000001, 5'd9, 32'h33, 32'h0);
    tick(3);
    check("spec_held", 64'(exp_q.size()), 64'd0);
    ents[8].speculative_tag = 6'd0;
    push_exp(2'b01, 4'd8, 4'd0, 2'b01, 5'd9, 5'd0, 32'h33, 32'h0);
    drain("spec_drain");

    // tag wrap: tag 0 is older than tag 31
    ents[10] = mk_ent(S_EXECUTED, ALU, 5'd0, 6'd0, 5'd10, 32'h1000, 32'h0);
    ents[11] = mk_ent(S_EXECUTED, ALU, 5'd31, 6'd0, 5'd11, 32'h1100, 32'h0);
    push_exp(2'b11, 4'd10, 4'd11, 2'b11, 5'd10, 5'd11, 32'h1000, 32'h1100);
    drain("wrap_drain");

    // destination x0 releases without a register write
    ents[12] = mk_ent(S_EXECUTED, ALU, 5'd5, 6'd0, 5'd0, 32'hDEAD, 32'h0);
    ents[13] = mk_ent(S_EXECUTED, ALU, 5'd4, 6'd0, 5'd2, 32'h22, 32'h0);
    push_exp(2'b11, 4'd12, 4'd13, 2'b10, 5'd0, 5'd2, 32'h0, 32'h22);
    drain("dest0_drain");

    // mem_ack while idle has no effect
    mem_ack = 1'b1;
    tick(2);
    mem_ack = 1'b0;
    check("idle_ack_mem_req", 64'(mem_req), 64'd0);
    check("idle_ack_state", 64'(dbg_state), 64'd0);
    drain("idle_ack_drain");

`ifdef COMMIT_PERF_CNT_EN
    check("retired_count", 64'(retired_count), 64'(exp_retired));
`endif

    // reset during an outstanding store
    ents[14] = mk_ent(S_EXECUTED, STORE, 5'd7, 6'd0, 5'd0, 32'h300, 32'h77);
    step();
    check("pre_reset_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_req", 64'(mem_req), 64'd0);
    check("reset_fsm_idle", 64'(dbg_state), 64'd0);
    check("reset_release", 64'(release_valid), 64'd0);
`ifdef COMMIT_PERF_CNT_EN
    check("reset_retired_count", 64'(retired_count), 64'd0);
`endif
    ents = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain("post_reset_drain");
    check("post_reset_mem_req", 64'(mem_req), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
